pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 160, giving the payload width in bits (bundled D->E style fields).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the stall-counter width.
REQ-003 The block SHALL have port clk  input  1  as its only clock, with every register updated on its rising edge.
REQ-004 The block SHALL have port rst  input  1  as a synchronous, active-high reset.
REQ-005 The block SHALL have port flush  input  1  to kill all held entries on the next edge.
REQ-006 The block SHALL have port in_valid  input  1  to mark the upstream payload as valid.
REQ-007 The block SHALL have port in_ready  output  1  to indicate that the stage accepts a payload this cycle.
REQ-008 The block SHALL have port in_data  input  DATA_W  carrying the upstream payload.
REQ-009 The block SHALL have port out_valid  output  1  to mark out_data as valid.
REQ-010 The block SHALL have port out_ready  input  1  to indicate that downstream accepts this cycle.
REQ-011 The block SHALL have port out_data  output  DATA_W  carrying the registered payload.
REQ-012 The block SHALL have port stall_cnt  output  CNT_W  counting backpressure cycles.

Function
REQ-013 Transfers SHALL occur only on edges where valid&ready=1 at that interface: in_fire=in_valid&in_ready and out_fire=out_valid&out_ready.
REQ-014 out_data SHALL come directly from a register, with no combinational path from in_data to out_data.
REQ-015 Latency from in_fire to out_valid SHALL be 1 cycle when the stage is empty.
REQ-016 Data order SHALL be preserved, and no payload SHALL be duplicated or dropped except by flush or rst.
REQ-017 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-018 When flush=1, all valid bits SHALL clear and all payload registers SHALL load zero at the next edge; in_fire during a flush cycle SHALL be discarded.
REQ-019 Priority SHALL be rst > flush > normal update.
REQ-020 stall_cnt SHALL increment by 1 on every edge with out_valid=1 and out_ready=0.
REQ-021 stall_cnt SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-022 stall_cnt SHALL be unaffected by flush and cleared only by rst.
REQ-023 Simultaneous in_fire and out_fire with one entry held SHALL replace the entry with no bubble (full throughput, 1 transfer/cycle).

Reset
REQ-024 While rst=1 at an edge, the block SHALL set out_valid=0, out_data=0, stall_cnt=0 and clear all internal valid bits and payloads.
REQ-025 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-026 rst asserted mid-transfer SHALL discard all held data, with no partial output afterwards.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN SHALL select the stage structure.
REQ-028 With PIPE_STAGE_SKID_EN defined, the block SHALL contain a main register plus a one-entry skid register.
- in_ready SHALL be a register output equal to ~skid_valid.
- An in_fire while main is valid and out_fire is absent SHALL write the skid entry.
- On out_fire, main SHALL load from skid if skid is valid, else from in_data if in_fire.
- Capacity SHALL be 2.
- in_ready SHALL deassert the cycle after the skid entry fills and reassert the cycle after it drains.
REQ-029 Without PIPE_STAGE_SKID_EN, the block SHALL contain a single register.
- in_ready SHALL be out_ready | ~out_valid, combinational from out_ready.
- Capacity SHALL be 1.
REQ-030 Interface, flush, reset and counter behaviour SHALL be identical in both builds.

Verification
REQ-031 Bench SHALL drive rst for 2 cycles, then idle, and check out_valid=0, out_data=0, stall_cnt=0, in_ready=1.
REQ-032 Bench SHALL stream 0x1..0x8 with out_ready=1 constantly and check that outputs appear 1 cycle after input, 8 transfers in 8 cycles, in order.
REQ-033 Bench SHALL send 0xA then 0xB with out_ready=0 for 5 cycles.
- Skid build: both accepted, in_ready=0 after the 2nd accept, out_data holds 0xA, stall_cnt=5; on release, 0xA then 0xB are output.
- Non-skid build: only 0xA accepted.
REQ-034 Bench SHALL assert flush with 2 entries held (skid build) and in_valid=1 with 0xC, then check out_valid=0 next cycle, 0xC not delivered, and stall_cnt unchanged.
REQ-035 Bench SHALL build with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles, and check that stall_cnt=15 and stays there.
REQ-036 Bench SHALL assert rst while 0xD is held and backpressured, and check out_valid=0 next cycle and that 0xD never appears.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// =============================================================================
// Module   : pipe_stage_reg
// Purpose  : Valid/ready pipeline register with a saturating backpressure
//            counter. Define PIPE_STAGE_SKID_EN for a main + one-entry skid
//            buffer (capacity 2, registered in_ready); otherwise the stage
//            is a single register with in_ready = out_ready | ~out_valid.
// Revision : 1.0 - initial release
// =============================================================================
module pipe_stage_reg #(
    parameter int DATA_W = 160,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;

    // in_ready depends only on skid state, so it never sees out_ready combinationally.
    assign in_ready = ~skid_valid;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_fire) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                main_data  <= in_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_fire) begin
            if (main_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end else begin
                main_valid <= 1'b1;
                main_data  <= in_data;
            end
        end
    end
`else
    assign in_ready = out_ready | ~main_valid;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_valid <= 1'b0;
            main_data  <= '0;
        end else if (in_fire) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
        end else if (out_fire) begin
            main_valid <= 1'b0;
        end
    end
`endif

    // Flush deliberately leaves the counter alone; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Directed testbench for pipe_stage_reg (default and PIPE_STAGE_SKID_EN builds).
// A second instance with CNT_W=4 exercises counter saturation.
module tb_pipe_stage_reg;

    localparam int DW  = 160;
    localparam int CW  = 16;
    localparam int SDW = 8;
    localparam int SCW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] stall_cnt;

    logic           s_rst = 1'b0;
    logic           s_flush = 1'b0;
    logic           s_in_valid = 1'b0;
    logic           s_in_ready;
    logic [SDW-1:0] s_in_data = '0;
    logic           s_out_valid;
    logic           s_out_ready = 1'b0;
    logic [SDW-1:0] s_out_data;
    logic [SCW-1:0] s_stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(SDW), .CNT_W(SCW)) dut_sat (
        .clk(clk), .rst(s_rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .stall_cnt(s_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_rst = 1'b1;
        tick(); tick();
        rst = 1'b0; s_rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
        checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL reset_sat_out_valid got=%0b exp=0", s_out_valid); end
        checks++; if (s_stall_cnt !== '0) begin failures++; $display("FAIL reset_sat_stall_cnt got=%0d exp=0", s_stall_cnt); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%0b exp=1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_out_valid[%0d] got=%0b exp=1", i, out_valid); end
            checks++; if (out_data !== DW'(i)) begin failures++; $display("FAIL stream_out_data[%0d] got=%0h exp=%0h", i, out_data, i); end
        end
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drained got=%0b exp=0", out_valid); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL stream_stall_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'('hA);
        tick();
        in_data = DW'('hB);
`ifndef PIPE_STAGE_SKID_EN
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full got=%0b exp=0", in_ready); end
`else
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_skid_free got=%0b exp=1", in_ready); end
`endif
        tick();
        in_valid = 1'b0;
        in_data  = '0;
`ifdef PIPE_STAGE_SKID_EN
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_after_2nd got=%0b exp=0", in_ready); end
`endif
        // Four more backpressured edges gives five in total since 0xA landed.
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_data !== DW'('hA) || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold[%0d] got=%0b/%0h exp=1/a", i, out_valid, out_data); end
            tick();
        end
        checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp=5", stall_cnt); end
        checks++; if (out_data !== DW'('hA)) begin failures++; $display("FAIL bp_out_data got=%0h exp=a", out_data); end
        out_ready = 1'b1;
        tick();
`ifdef PIPE_STAGE_SKID_EN
        checks++; if (out_valid !== 1'b1 || out_data !== DW'('hB)) begin failures++; $display("FAIL bp_second_out got=%0b/%0h exp=1/b", out_valid, out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_drained got=%0b exp=1", in_ready); end
        tick();
`endif
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0b exp=0", out_valid); end
        checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL bp_stall_after got=%0d exp=5", stall_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'('h11);
        tick();
        in_data = DW'('h22);
        tick();
`ifdef PIPE_STAGE_SKID_EN
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_two_held got=%0b exp=0", in_ready); end
`endif
        flush     = 1'b1;
        in_data   = DW'('hC);
        out_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL flush_out_data got=%0h exp=0", out_data); end
        checks++; if (stall_cnt !== 16'd6) begin failures++; $display("FAIL flush_stall_cnt got=%0d exp=6", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_c[%0d] got=%0b/%0h exp=0", i, out_valid, out_data); end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'('hD);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== DW'('hD)) begin failures++; $display("FAIL rmid_held got=%0b/%0h exp=1/d", out_valid, out_data); end
        checks++; if (stall_cnt !== 16'd7) begin failures++; $display("FAIL rmid_stall_before got=%0d exp=7", stall_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%0b exp=0", out_valid); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rmid_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%0b exp=1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_data !== '0) begin failures++; $display("FAIL rmid_no_d[%0d] got=%0b/%0h exp=0/0", i, out_valid, out_data); end
        end
    endtask

    task automatic test_saturate();
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 8'h5A;
        tick();
        s_in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 3) begin
                checks++; if (s_stall_cnt !== 4'd3) begin failures++; $display("FAIL sat_mid got=%0d exp=3", s_stall_cnt); end
            end
            if (k == 15) begin
                checks++; if (s_stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_reach got=%0d exp=15", s_stall_cnt); end
            end
        end
        checks++; if (s_out_valid !== 1'b1 || s_out_data !== 8'h5A) begin failures++; $display("FAIL sat_hold got=%0b/%0h exp=1/5a", s_out_valid, s_out_data); end
        checks++; if (s_stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_20 got=%0d exp=15", s_stall_cnt); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (s_stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_stay[%0d] got=%0d exp=15", k, s_stall_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
